// File: rtl/usb_ep_ring.sv
// usb_ep_ring: multi-channel byte ring buffer for USB endpoints with packet commit/discard.
// Writes land behind a speculative pointer; only committed bytes become visible to the reader.
module usb_ep_ring #(
  parameter int NUM_CH     = 2,
  parameter int DEPTH_LOG2 = 6,
  parameter int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CW-1:0]                    wr_ch,
  input  logic [7:0]                       wr_data,
  input  logic                             wr_en,
  input  logic                             wr_commit,
  input  logic                             wr_discard,
  output logic                             wr_full,
  output logic                             wr_err,
  input  logic [CW-1:0]                    rd_ch,
  input  logic                             rd_en,
  output logic [7:0]                       rd_data,
  output logic                             rd_valid,
  output logic                             rd_empty,
  input  logic [NUM_CH-1:0]                ch_flush,
  output logic [NUM_CH*(DEPTH_LOG2+1)-1:0] level
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam int AW = CW + DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PW-1:0] ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [PW-1:0]     rptr_q [NUM_CH];
  logic [PW-1:0]     rptr_d [NUM_CH];
  logic [PW-1:0]     wptr_q [NUM_CH];
  logic [PW-1:0]     wptr_d [NUM_CH];
  logic [PW-1:0]     sptr_q [NUM_CH];
  logic [PW-1:0]     sptr_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] full_vec;
  logic [NUM_CH-1:0] empty_vec;

  logic              wr_err_q, wr_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic              wr_ch_ok, rd_ch_ok;
  logic              wr_acc, rd_acc;
  logic [AW-1:0]     wr_addr, rd_addr;

  logic [7:0]        mem [NUM_CH*(2**DEPTH_LOG2)];

  // The extra pointer bit separates a full ring from an empty one.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign full_vec[i]       = (sptr_q[i] - rptr_q[i]) == DEPTH;
    assign empty_vec[i]      = (wptr_q[i] == rptr_q[i]);
    assign level[i*PW +: PW] = wptr_q[i] - rptr_q[i];
  end

  assign wr_ch_ok = (int'(wr_ch) < NUM_CH);
  assign rd_ch_ok = (int'(rd_ch) < NUM_CH);
  assign wr_full  = wr_ch_ok ? full_vec[wr_ch]  : 1'b1;
  assign rd_empty = rd_ch_ok ? empty_vec[rd_ch] : 1'b1;
  assign wr_addr  = {wr_ch, sptr_q[wr_ch][DEPTH_LOG2-1:0]};
  assign rd_addr  = {rd_ch, rptr_q[rd_ch][DEPTH_LOG2-1:0]};

  always_comb begin
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    sptr_d   = sptr_q;
    ovf_d    = ovf_q;
    wr_acc   = 1'b0;
    rd_acc   = 1'b0;
    wr_err_d = 1'b0;

    if (wr_ch_ok && !ch_flush[wr_ch]) begin
      if (wr_discard) begin
        sptr_d[wr_ch] = wptr_q[wr_ch];
        ovf_d[wr_ch]  = 1'b0;
      end else begin
        if (wr_en && !full_vec[wr_ch]) begin
          wr_acc        = 1'b1;
          sptr_d[wr_ch] = sptr_q[wr_ch] + ONE;
        end else if (wr_en) begin
          ovf_d[wr_ch] = 1'b1;
        end
        // A byte dropped in the commit cycle itself still poisons the packet.
        if (wr_commit) begin
          if (ovf_d[wr_ch]) begin
            sptr_d[wr_ch] = wptr_q[wr_ch];
            ovf_d[wr_ch]  = 1'b0;
            wr_err_d      = 1'b1;
          end else begin
            wptr_d[wr_ch] = sptr_d[wr_ch];
          end
        end
      end
    end

    if (rd_ch_ok && !ch_flush[rd_ch] && rd_en && !empty_vec[rd_ch]) begin
      rd_acc        = 1'b1;
      rptr_d[rd_ch] = rptr_q[rd_ch] + ONE;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_flush[i]) begin
        rptr_d[i] = '0;
        wptr_d[i] = '0;
        sptr_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end
    end
  end

  assign rd_data_d  = rd_acc ? mem[rd_addr] : rd_data_q;
  assign rd_valid_d = rd_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rptr_q[i] <= '0;
        wptr_q[i] <= '0;
        sptr_q[i] <= '0;
      end
      ovf_q      <= '0;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      sptr_q     <= sptr_d;
      ovf_q      <= ovf_d;
      wr_err_q   <= wr_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign wr_err   = wr_err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_usb_ep_ring.sv
// tb_usb_ep_ring: directed scoreboard bench for usb_ep_ring (2 channels, 64 bytes each).
// A queue model of each channel predicts levels, flags, read data and commit errors.
module tb_usb_ep_ring;

  localparam int NUM_CH = 2;
  localparam int DL     = 6;
  localparam int PW     = DL + 1;
  localparam int CW     = 1;
  localparam int DEPTH  = 64;

  logic                  clk;
  logic                  rst_n;
  logic [CW-1:0]         wr_ch;
  logic [7:0]            wr_data;
  logic                  wr_en;
  logic                  wr_commit;
  logic                  wr_discard;
  logic                  wr_full;
  logic                  wr_err;
  logic [CW-1:0]         rd_ch;
  logic                  rd_en;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  rd_empty;
  logic [NUM_CH-1:0]     ch_flush;
  logic [NUM_CH*PW-1:0]  level;

  usb_ep_ring #(.NUM_CH(NUM_CH), .DEPTH_LOG2(DL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_commit  (wr_commit),
    .wr_discard (wr_discard),
    .wr_full    (wr_full),
    .wr_err     (wr_err),
    .rd_ch      (rd_ch),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_empty   (rd_empty),
    .ch_flush   (ch_flush),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         lv [2];
  int         pd [2];
  bit         ov [2];
  logic [7:0] sb   [$];
  logic [7:0] pend [$];
  logic [7:0] rdq  [$];
  logic [7:0] last_rd = 8'h00;
  bit         last_known = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model predicts the outcome, outputs are checked 1 time unit after the edge.
  task automatic applyStimulus(input int wc, input logic [7:0] wd, input bit we, input bit wcm,
                               input bit wds, input int rc, input bit re, input logic [1:0] fl);
    bit         exp_valid;
    bit         exp_err;
    bit         full;
    logic [7:0] exp_byte;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    full      = (lv[wc] + pd[wc]) == DEPTH;
    wr_ch = CW'(wc); wr_data = wd; wr_en = we; wr_commit = wcm; wr_discard = wds;
    rd_ch = CW'(rc); rd_en = re; ch_flush = fl;

    if (re && !fl[rc] && lv[rc] > 0) begin
      lv[rc]--;
      exp_valid = 1'b1;
      if (rc == 0) rdq.push_back(sb.pop_front());
    end
    if (!fl[wc]) begin
      if (wds) begin
        pd[wc] = 0; ov[wc] = 1'b0;
        if (wc == 0) pend.delete();
      end else begin
        if (we && !full) begin
          pd[wc]++;
          if (wc == 0) pend.push_back(wd);
        end else if (we) begin
          ov[wc] = 1'b1;
        end
        if (wcm) begin
          if (ov[wc]) begin
            pd[wc] = 0; ov[wc] = 1'b0; exp_err = 1'b1;
            if (wc == 0) pend.delete();
          end else begin
            lv[wc] += pd[wc]; pd[wc] = 0;
            if (wc == 0) while (pend.size() > 0) sb.push_back(pend.pop_front());
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (fl[i]) begin
        lv[i] = 0; pd[i] = 0; ov[i] = 1'b0;
        if (i == 0) begin sb.delete(); pend.delete(); end
      end
    end

    @(posedge clk); #1;
    wr_en = 1'b0; wr_commit = 1'b0; wr_discard = 1'b0; rd_en = 1'b0; ch_flush = '0;

    checkOutput("rd_valid", 32'(rd_valid), 32'(exp_valid));
    if (exp_valid && rc == 0) begin
      exp_byte = rdq.pop_front();
      checkOutput("rd_data", 32'(rd_data), 32'(exp_byte));
      last_rd = exp_byte; last_known = 1'b1;
    end else if (exp_valid) begin
      last_known = 1'b0;
    end else if (last_known) begin
      checkOutput("rd_hold", 32'(rd_data), 32'(last_rd));
    end
    checkOutput("wr_err", 32'(wr_err), 32'(exp_err));
    checkOutput("level0", 32'(level[PW-1:0]), 32'(lv[0]));
    checkOutput("level1", 32'(level[2*PW-1:PW]), 32'(lv[1]));
  endtask

  task automatic checkFlags(input int wc, input int rc);
    wr_ch = CW'(wc); rd_ch = CW'(rc);
    #1;
    checkOutput("wr_full", 32'(wr_full), 32'((lv[wc] + pd[wc]) == DEPTH));
    checkOutput("rd_empty", 32'(rd_empty), 32'(lv[rc] == 0));
  endtask

  task automatic wrByte(input int ch, input logic [7:0] d);
    applyStimulus(ch, d, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2'b00);
  endtask

  task automatic commitPkt(input int ch);
    applyStimulus(ch, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 2'b00);
  endtask

  task automatic discardPkt(input int ch);
    applyStimulus(ch, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 2'b00);
  endtask

  task automatic readByte(input int ch);
    applyStimulus(0, 8'h00, 1'b0, 1'b0, 1'b0, ch, 1'b1, 2'b00);
  endtask

  task automatic resetModel;
    for (int i = 0; i < 2; i++) begin lv[i] = 0; pd[i] = 0; ov[i] = 1'b0; end
    sb.delete(); pend.delete(); rdq.delete();
    last_rd = 8'h00; last_known = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wr_ch = '0; wr_data = '0; wr_en = 1'b0; wr_commit = 1'b0; wr_discard = 1'b0;
    rd_ch = '0; rd_en = 1'b0; ch_flush = '0;
    rst_n = 1'b1;
    resetModel();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("[TB] reset state");
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkFlags(0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic packet on ch0");
    for (int i = 0; i < 4; i++) wrByte(0, 8'h10 + 8'(i));
    checkFlags(0, 0);
    commitPkt(0);
    checkFlags(0, 0);
    checkFlags(1, 1);
    for (int i = 0; i < 4; i++) readByte(0);
    checkFlags(0, 0);
    readByte(0);

    $display("[TB] discard on ch1 then full packet");
    for (int i = 0; i < 5; i++) wrByte(1, 8'hA0 + 8'(i));
    discardPkt(1);
    for (int i = 0; i < DEPTH; i++) begin
      checkFlags(1, 1);
      wrByte(1, 8'(i));
    end
    checkFlags(1, 1);
    discardPkt(1);

    $display("[TB] overflow on ch0");
    for (int i = 0; i < DEPTH; i++) wrByte(0, 8'(8'hC0 ^ i));
    checkFlags(0, 0);
    wrByte(0, 8'hEE);
    checkFlags(0, 0);
    commitPkt(0);
    checkFlags(0, 0);

    $display("[TB] streaming across the wrap");
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 40; i++) wrByte(0, 8'($urandom));
      commitPkt(0);
      for (int i = 0; i < 40; i++) readByte(0);
    end
    checkFlags(0, 0);

    $display("[TB] simultaneous write, commit and read on ch0");
    wrByte(0, 8'h3C);
    commitPkt(0);
    applyStimulus(0, 8'h4D, 1'b1, 1'b1, 1'b0, 0, 1'b1, 2'b00);
    checkFlags(0, 0);
    readByte(0);

    $display("[TB] flush of ch1 mid-packet");
    wrByte(0, 8'h5A);
    commitPkt(0);
    for (int i = 0; i < 10; i++) wrByte(1, 8'h60 + 8'(i));
    commitPkt(1);
    for (int i = 0; i < 3; i++) wrByte(1, 8'h70 + 8'(i));
    applyStimulus(1, 8'h7F, 1'b1, 1'b0, 1'b0, 1, 1'b1, 2'b10);
    checkFlags(1, 1);
    checkFlags(0, 0);

    $display("[TB] asynchronous reset mid-read");
    wrByte(0, 8'hC3);
    commitPkt(0);
    readByte(0);
    rd_ch = '0; rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("arst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("arst_rd_data", 32'(rd_data), 32'd0);
    checkOutput("arst_level", 32'(level), 32'd0);
    checkOutput("arst_wr_err", 32'(wr_err), 32'd0);
    checkFlags(0, 0);
    rd_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wrByte(0, 8'h77);
    commitPkt(0);
    readByte(0);
    checkFlags(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
